// File: rtl/guess_scorer.sv
// Guess-number scorer: snapshots question/answer digits on start, validates the
// guess, scores it as xAyB over four scan cycles and tracks attempts/win/game-over.
module guess_scorer #(
  parameter int MAX_ATTEMPTS = 10,
  parameter int ATT_W        = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             new_game,
  input  logic [3:0]       q1,
  input  logic [3:0]       q2,
  input  logic [3:0]       q3,
  input  logic [3:0]       q4,
  input  logic [3:0]       a1,
  input  logic [3:0]       a2,
  input  logic [3:0]       a3,
  input  logic [3:0]       a4,
  output logic             busy,
  output logic             done,
  output logic [2:0]       a_count,
  output logic [2:0]       b_count,
  output logic             valid_guess,
  output logic             win,
  output logic             game_over,
  output logic [ATT_W-1:0] attempts
);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, REPORT} state_t;

  state_t          state_reg, state_next;
  logic            pend_reg, pend_next;
  logic [1:0]      idx_reg, idx_next;
  logic [2:0]      acc_a_reg, acc_a_next;
  logic [2:0]      acc_b_reg, acc_b_next;
  logic [3:0][3:0] q_reg, q_next;
  logic [3:0][3:0] a_reg, a_next;
  logic [2:0]      a_count_reg, a_count_next;
  logic [2:0]      b_count_reg, b_count_next;
  logic            valid_reg, valid_next;
  logic            win_reg, win_next;
  logic            game_over_reg, game_over_next;
  logic [ATT_W-1:0] attempts_reg, attempts_next;

  logic [3:0]  cur_a;
  logic [3:0]  q_match;
  logic [3:0]  over9;
  logic [15:0] pair_eq;
  logic        illegal;
  logic        hit_a;
  logic        hit_b;
  logic [2:0]  final_a;
  logic [2:0]  final_b;

  assign cur_a = a_reg[idx_reg];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign q_match[gi] = (cur_a == q_reg[gi]);
      assign over9[gi]   = (a_reg[gi] > 4'd9);
      // Upper triangle of the answer-digit equality matrix gives the 6 pairwise compares
      for (gj = 0; gj < 4; gj++) begin : g_pair
        if (gj > gi) begin : g_cmp
          assign pair_eq[gi*4+gj] = (a_reg[gi] == a_reg[gj]);
        end else begin : g_zero
          assign pair_eq[gi*4+gj] = 1'b0;
        end
      end
    end
  endgenerate

  assign illegal = (|over9) || (|pair_eq);
  assign hit_a   = q_match[idx_reg];
  assign hit_b   = !hit_a && (|q_match);
  assign final_a = acc_a_reg + 3'(hit_a);
  assign final_b = acc_b_reg + 3'(hit_b);

  always_comb begin
    state_next     = state_reg;
    pend_next      = pend_reg;
    idx_next       = idx_reg;
    acc_a_next     = acc_a_reg;
    acc_b_next     = acc_b_reg;
    q_next         = q_reg;
    a_next         = a_reg;
    a_count_next   = a_count_reg;
    b_count_next   = b_count_reg;
    valid_next     = valid_reg;
    win_next       = win_reg;
    game_over_next = game_over_reg;
    attempts_next  = attempts_reg;

    if (new_game) begin
      state_next     = IDLE;
      pend_next      = 1'b0;
      a_count_next   = 3'd0;
      b_count_next   = 3'd0;
      valid_next     = 1'b0;
      win_next       = 1'b0;
      game_over_next = 1'b0;
      attempts_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Start is captured with its digits on the sampling edge, acted on one edge later
          if (pend_reg) begin
            state_next = CHECK;
            pend_next  = 1'b0;
            acc_a_next = 3'd0;
            acc_b_next = 3'd0;
          end else if (start && !win_reg && !game_over_reg) begin
            pend_next = 1'b1;
            q_next    = {q4, q3, q2, q1};
            a_next    = {a4, a3, a2, a1};
          end
        end
        CHECK: begin
          if (illegal) begin
            state_next   = REPORT;
            a_count_next = 3'd0;
            b_count_next = 3'd0;
            valid_next   = 1'b0;
          end else begin
            state_next = SCAN;
            idx_next   = 2'd0;
          end
        end
        SCAN: begin
          acc_a_next = final_a;
          acc_b_next = final_b;
          idx_next   = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            // Results land on entry to REPORT so they are valid alongside done
            state_next    = REPORT;
            a_count_next  = final_a;
            b_count_next  = final_b;
            valid_next    = 1'b1;
            attempts_next = attempts_reg + ATT_W'(1);
            if (final_a == 3'd4) begin
              win_next = 1'b1;
            end else if (attempts_next == ATT_W'(MAX_ATTEMPTS)) begin
              game_over_next = 1'b1;
            end
          end
        end
        REPORT: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pend_reg      <= 1'b0;
      idx_reg       <= 2'd0;
      acc_a_reg     <= 3'd0;
      acc_b_reg     <= 3'd0;
      q_reg         <= '0;
      a_reg         <= '0;
      a_count_reg   <= 3'd0;
      b_count_reg   <= 3'd0;
      valid_reg     <= 1'b0;
      win_reg       <= 1'b0;
      game_over_reg <= 1'b0;
      attempts_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= pend_next;
      idx_reg       <= idx_next;
      acc_a_reg     <= acc_a_next;
      acc_b_reg     <= acc_b_next;
      q_reg         <= q_next;
      a_reg         <= a_next;
      a_count_reg   <= a_count_next;
      b_count_reg   <= b_count_next;
      valid_reg     <= valid_next;
      win_reg       <= win_next;
      game_over_reg <= game_over_next;
      attempts_reg  <= attempts_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == REPORT);
  assign a_count     = a_count_reg;
  assign b_count     = b_count_reg;
  assign valid_guess = valid_reg;
  assign win         = win_reg;
  assign game_over   = game_over_reg;
  assign attempts    = attempts_reg;

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: scoreboard of expected xAyB results and
// game status, plus latency, ignore, abort and async-reset scenarios.
module tb_guess_scorer;

  localparam int MAXA = 3;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       new_game;
  logic [3:0] q1, q2, q3, q4, a1, a2, a3, a4;
  logic       busy, done, valid_guess, win, game_over;
  logic [2:0] a_count, b_count;
  logic [3:0] attempts;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       v;
    logic       w;
    logic       g;
    logic [3:0] att;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_att    = 0;
  logic m_win    = 1'b0;
  logic m_go     = 1'b0;

  guess_scorer #(.MAX_ATTEMPTS(MAXA), .ATT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .new_game(new_game),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .busy(busy), .done(done), .a_count(a_count), .b_count(b_count),
    .valid_guess(valid_guess), .win(win), .game_over(game_over), .attempts(attempts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_digits(input logic [15:0] qv, input logic [15:0] av);
    {q4, q3, q2, q1} = qv;
    {a4, a3, a2, a1} = av;
  endtask

  // Reference scoring from the xAyB definition; updates the game-status model
  function automatic res_t model(input logic [15:0] qv, input logic [15:0] av);
    res_t r;
    logic legal;
    int na, nb;
    legal = 1'b1;
    na = 0;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (av[i*4 +: 4] > 4'd9) legal = 1'b0;
      for (int j = i + 1; j < 4; j++)
        if (av[i*4 +: 4] == av[j*4 +: 4]) legal = 1'b0;
    end
    if (legal) begin
      for (int i = 0; i < 4; i++) begin
        if (av[i*4 +: 4] == qv[i*4 +: 4]) na++;
        else begin
          for (int j = 0; j < 4; j++)
            if (j != i && av[i*4 +: 4] == qv[j*4 +: 4]) begin
              nb++;
              break;
            end
        end
      end
      m_att++;
      if (na == 4) m_win = 1'b1;
      else if (m_att == MAXA) m_go = 1'b1;
    end
    r.a   = legal ? 3'(na) : 3'd0;
    r.b   = legal ? 3'(nb) : 3'd0;
    r.v   = legal;
    r.w   = m_win;
    r.g   = m_go;
    r.att = 4'(m_att);
    return r;
  endfunction

  task automatic do_guess(input string name, input logic [15:0] qv, input logic [15:0] av);
    res_t exp_r, got;
    int k, lat;
    @(negedge clock);
    set_digits(qv, av);
    start = 1'b1;
    exp_r = model(qv, av);
    exp_q.push_back(exp_r);
    lat = exp_r.v ? 6 : 2;
    @(negedge clock);
    start = 1'b0;
    set_digits(16'h0000, 16'hFFFF);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clock);
      k++;
    end
    exp_r = exp_q.pop_front();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, k);
    end else begin
      got = {a_count, b_count, valid_guess, win, game_over, attempts};
      if (k != lat || busy !== 1'b1 || got !== exp_r) begin
        failures++;
        $display("FAIL %s: lat=%0d busy=%b got a=%0d b=%0d v=%b w=%b g=%b att=%0d, need lat=%0d busy=1 a=%0d b=%0d v=%b w=%b g=%b att=%0d",
                 name, k, busy, got.a, got.b, got.v, got.w, got.g, got.att,
                 lat, exp_r.a, exp_r.b, exp_r.v, exp_r.w, exp_r.g, exp_r.att);
      end else begin
        $display("txn %s: q=%h a=%h -> %0dA%0dB valid=%b win=%b over=%b att=%0d lat=%0d",
                 name, qv, av, got.a, got.b, got.v, got.w, got.g, got.att, k);
      end
    end
    @(negedge clock);
  endtask

  task automatic pulse_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    m_att = 0;
    m_win = 1'b0;
    m_go  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, a_count, b_count, valid_guess, win, game_over, attempts} !== 15'd0) begin
      failures++;
      $display("FAIL reset: outputs=%b need all zero",
               {busy, done, a_count, b_count, valid_guess, win, game_over, attempts});
    end else $display("txn reset: all outputs zero");
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_ignored_start(input string name);
    int nb, nd;
    nb = 0;
    nd = 0;
    @(negedge clock);
    set_digits(16'h1234, 16'h5678);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) nb++;
      if (done) nd++;
      @(negedge clock);
    end
    checks++;
    if (nb != 0 || nd != 0 || attempts !== 4'(m_att)) begin
      failures++;
      $display("FAIL %s: busy_cycles=%0d done_cycles=%0d att=%0d, need 0 0 att=%0d",
               name, nb, nd, attempts, m_att);
    end else $display("txn %s: start ignored, att=%0d", name, attempts);
  endtask

  task automatic test_abort();
    int nd;
    @(negedge clock);
    set_digits(16'h1234, 16'h1243);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    m_att = 0;
    m_win = 1'b0;
    m_go  = 1'b0;
    checks++;
    if (busy !== 1'b0 || attempts !== 4'd0 || win !== 1'b0 || a_count !== 3'd0 || valid_guess !== 1'b0) begin
      failures++;
      $display("FAIL abort: busy=%b att=%0d win=%b a=%0d v=%b, need all zero",
               busy, attempts, win, a_count, valid_guess);
    end
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      @(negedge clock);
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL abort_done: done_cycles=%0d need 0", nd);
    end else $display("txn abort: scoring cancelled, no done");
    // new_game and start together: start must be dropped
    set_digits(16'h1234, 16'h4321);
    start    = 1'b1;
    new_game = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    new_game = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) nd++;
      @(negedge clock);
    end
    checks++;
    if (nd != 0 || attempts !== 4'd0) begin
      failures++;
      $display("FAIL newgame_start: active_cycles=%0d att=%0d, need 0 0", nd, attempts);
    end else $display("txn newgame_start: start ignored");
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    set_digits(16'h1234, 16'h1243);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, a_count, b_count, valid_guess, win, game_over, attempts} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset: outputs=%b need all zero before any edge",
               {busy, done, a_count, b_count, valid_guess, win, game_over, attempts});
    end else $display("txn async_reset: outputs cleared without clock");
    exp_q.delete();
    m_att = 0;
    m_win = 1'b0;
    m_go  = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    new_game = 1'b0;
    set_digits(16'h0000, 16'h0000);
    test_reset();
    do_guess("exact", 16'h1234, 16'h1234);
    test_ignored_start("start_after_win");
    pulse_new_game();
    do_guess("permutation", 16'h1234, 16'h4321);
    do_guess("mixed", 16'h1234, 16'h1325);
    do_guess("illegal_dup", 16'h1234, 16'h1123);
    do_guess("illegal_gt9", 16'h1234, 16'h123A);
    test_abort();
    do_guess("pre_reset", 16'h9870, 16'h0789);
    test_async_reset();
    do_guess("after_reset", 16'h9870, 16'h9807);
    pulse_new_game();
    do_guess("exhaust1", 16'h1234, 16'h5678);
    do_guess("exhaust2", 16'h1234, 16'h2143);
    do_guess("exhaust3", 16'h5670, 16'h5607);
    test_ignored_start("start_after_over");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/guess_scorer.md
Name: guess_scorer

Overview:
- Downstream stage of the question/answer digit-entry controller in the guess-number game.
- Snapshots the four question digits (q1..q4) and four answer digits (a1..a4) on a start pulse.
- Validates the guess and scores it sequentially as xAyB:
  - A = right digit in the right position.
  - B = right digit in the wrong position.
- Tracks the attempt count, win and game-over, and feeds the result display.

Parameters:
MAX_ATTEMPTS, 10, number of valid guesses allowed before game_over (range 1..15)
ATT_W, 4, width of attempts counter

Ports:
clock  input  1  system clock, all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to score the current digits
new_game  input  1  one-cycle request: clear game status, abort any scoring
q1,q2,q3,q4  input  4 each  question digits (q1 = rightmost position)
a1,a2,a3,a4  input  4 each  answer/guess digits (a1 = rightmost position)
busy  output  1  high while not in IDLE
done  output  1  one-cycle pulse, result outputs valid
a_count  output  3  A score, 0..4
b_count  output  3  B score, 0..4
valid_guess  output  1  last scored guess was legal
win  output  1  sticky, set on 4A with a legal guess
game_over  output  1  sticky, attempts reached MAX_ATTEMPTS without win
attempts  output  ATT_W  number of legal guesses scored this game

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE.
  - busy, done, a_count, b_count, valid_guess, win, game_over and attempts all go to 0.
  - Snapshot registers are cleared.
- FSM states: IDLE, CHECK, SCAN, REPORT.
- IDLE:
  - start=1 with win=0, game_over=0 and new_game=0 latches q1..q4 and a1..a4 into the snapshot, clears the A/B accumulators and goes to CHECK.
  - start is ignored while win or game_over is set.
- CHECK (1 cycle), guess is illegal if either holds:
  - any a digit is greater than 9;
  - any two a digits are equal (6 pairwise compares).
  - Illegal: go to REPORT with the illegal flag set. Legal: go to SCAN with idx=0.
- SCAN (4 cycles, idx 0..3), each cycle compares answer digit a[idx+1] against all four q digits:
  - Equal to q[idx+1]: A accumulator +1.
  - Otherwise equal to any other q[j]: B accumulator +1.
  - At most one increment per cycle. Equality is 4-bit exact; q digits are not validated.
  - After idx=3, go to REPORT.
- REPORT (1 cycle):
  - done=1. a_count, b_count and valid_guess are registered from the accumulators and flag; they hold until the next REPORT, new_game or reset.
  - If the guess was legal, attempts increments.
  - If legal and A=4, win is set.
  - Otherwise, if the new attempts equals MAX_ATTEMPTS, game_over is set.
  - If illegal: a_count=0, b_count=0, valid_guess=0; attempts, win and game_over are unchanged.
  - Next state is IDLE.
- Latency:
  - start sampled at edge N; done is high in the cycle after edge N+6 for a legal guess and after edge N+2 for an illegal one.
  - busy is high from edge N+1 until done's cycle inclusive.
- start while busy is ignored (no queueing). Input changes after the start edge do not affect the result.
- new_game has priority over everything except reset:
  - Next edge: FSM to IDLE; attempts, win, game_over, a_count, b_count and valid_guess cleared.
  - No done pulse for an aborted scoring.
  - A simultaneous start is ignored.
- attempts never exceeds MAX_ATTEMPTS, because start is blocked once game_over is set.
- Reset mid-operation aborts immediately; no done is produced.

Test Plan:
- Exact match: q4..q1=1,2,3,4 and a4..a1=1,2,3,4, start -> done 6 cycles later; a_count=4, b_count=0, valid_guess=1, win=1, attempts=1; a later start gives no busy and no done.
- Full permutation: q=1,2,3,4 and a=4,3,2,1 -> a_count=0, b_count=4, win=0, attempts=1. Mixed: a=1,3,2,5 -> a_count=1, b_count=2.
- Illegal guesses: a=1,1,2,3 -> done 2 cycles after start, valid_guess=0, a_count=0, b_count=0, attempts unchanged. Repeat with a1=4'hA -> same result.
- Exhaustion with MAX_ATTEMPTS=3: three legal non-winning guesses -> attempts=3, game_over=1; a fourth start is ignored (busy stays 0).
- Abort: new_game 3 cycles into SCAN -> no done, busy=0 next cycle, attempts=0, win=0. Also new_game and start in the same cycle -> start is ignored.
- Async reset: pull reset_n low mid-SCAN between clock edges -> outputs go to 0 immediately without a clock edge; after release, a fresh start scores correctly.
